// File: rtl/weight_mem_rsp.sv
// Weight SRAM read responder: accepts word reads, issues them to a fixed-latency SRAM and returns
// {addr, data} in order via a credit-protected FIFO. Define WMEM_RSP_ERR_EN for range checking and the err port.
module weight_mem_rsp #(
  parameter int          DATA_W     = 32,
  parameter int          MEM_AW     = 12,
  parameter int          SRAM_LAT   = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_addr,
  input  logic              req_vld,
  output logic              req_rdy,
  output logic [31:0]       rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic              sram_ren,
  output logic [MEM_AW-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic [15:0]       rd_cnt
`ifdef WMEM_RSP_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]  osd_q, osd_d;
  logic              accept, pop;
  logic [32:0]       off_full;
  logic              in_range;
  logic              unused_off;

  logic [SRAM_LAT-1:0] pipe_vld_q;
  logic [SRAM_LAT-1:0] pipe_ok_q;
  logic [31:0]         pipe_addr_q [SRAM_LAT];

  logic [31:0]       fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fifo_wr, fifo_full;
  logic [15:0]       rd_cnt_q, rd_cnt_d;

  // Stage 0: request accept and SRAM address issue
  assign off_full = {1'b0, req_addr} - {1'b0, BASE_ADDR};
`ifdef WMEM_RSP_ERR_EN
  assign in_range = !off_full[32] && (off_full[31:MEM_AW+2] == '0);
`else
  assign in_range = 1'b1;
`endif
  assign unused_off = ^{off_full[32:MEM_AW+2], off_full[1:0]};

  assign req_rdy    = !rst && (osd_q < DEPTH_C);
  assign accept     = req_vld && req_rdy;
  assign pop        = rsp_vld && rsp_rdy;
  assign sram_ren   = accept && in_range;
  assign sram_raddr = off_full[MEM_AW+1:2];

  always_comb begin
    osd_d = osd_q;
    if (accept && !pop)
      osd_d = osd_q + 1'b1;
    else if (!accept && pop)
      osd_d = osd_q - 1'b1;
  end

  // Latency pipe: tracks each accepted request until its SRAM data arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
    end else begin
      for (int i = SRAM_LAT - 1; i > 0; i--)
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      pipe_vld_q[0] <= accept;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = SRAM_LAT - 1; i > 0; i--) begin
      pipe_addr_q[i] <= pipe_addr_q[i-1];
      pipe_ok_q[i]   <= pipe_ok_q[i-1];
    end
    pipe_addr_q[0] <= req_addr;
    pipe_ok_q[0]   <= in_range;
  end

  // Response FIFO: written when the SRAM data lands, head drives the response channel
  assign fifo_wr   = pipe_vld_q[SRAM_LAT-1];
  assign fifo_full = (cnt_q == DEPTH_C);
  assign cnt_d     = cnt_q + CNT_W'(fifo_wr) - CNT_W'(pop);
  assign rd_cnt_d  = pop ? rd_cnt_q + 16'd1 : rd_cnt_q;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_addr_q[wr_ptr_q] <= pipe_addr_q[SRAM_LAT-1];
      fifo_data_q[wr_ptr_q] <= pipe_ok_q[SRAM_LAT-1] ? sram_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      osd_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      osd_q    <= osd_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rsp_vld  = (cnt_q != '0);
  assign rsp_addr = fifo_addr_q[rd_ptr_q];
  assign rsp_data = fifo_data_q[rd_ptr_q];
  assign busy     = (osd_q != '0);
  assign rd_cnt   = rd_cnt_q;

`ifdef WMEM_RSP_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept && !in_range)
      err_q <= 1'b1;
  end

  assign err = err_q;
`endif

`ifndef SYNTHESIS
  // The osd credit bound must keep the FIFO from ever being written while full
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full))
    else $error("weight_mem_rsp: response FIFO written while full");
`endif

endmodule
